neuron_mac_ctrl: RTL and testbench

NEURON_MAC_CTRL -- requirements
Module: neuron_mac_ctrl

---
 rtl/neuron_mac_ctrl.sv | 128 ++++++++++++
 tb/tb_neuron_mac_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_ctrl.sv
// Sequential neuron: accumulates len products from an external multiplier onto a bias,
// then applies shift and ReLU with positive saturation before a valid/ready handshake.
module neuron_mac_ctrl #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8,
    parameter int SHIFT  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    len,
    input  logic [2*WIDTH-1:0]   bias,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [WIDTH-1:0]     x_data,
    input  logic [WIDTH-1:0]     w_data,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    output logic                 mul_start,
    input  logic                 mul_ack,
    input  logic                 mul_done,
    input  logic [2*WIDTH-1:0]   mul_p,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 sat
);

    localparam int AW = 2*WIDTH + ADDR_W + 1;

    typedef enum logic [2:0] {IDLE, READ, LOAD, MREQ, MWAIT, POST, OUT} state_t;

    state_t                   state, state_nxt;
    logic signed [AW-1:0]     acc;
    logic signed [AW-1:0]     acc_sh;
    logic signed [AW-1:0]     bias_ext;
    logic signed [AW-1:0]     prod_ext;
    logic [ADDR_W-1:0]        idx;
    logic [ADDR_W-1:0]        idx_inc;
    logic [ADDR_W-1:0]        len_q;

    // Returns {sat, data}: negatives clamp to zero, large positives to the max code.
    function automatic logic [WIDTH:0] relu_sat(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] maxv;
        maxv = '0;
        maxv[WIDTH-2:0] = '1;
        if (v[AW-1])
            return '0;
        else if (v > maxv)
            return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
        else
            return {1'b0, v[WIDTH-1:0]};
    endfunction

    assign bias_ext = {{(AW-2*WIDTH){bias[2*WIDTH-1]}}, bias};
    assign prod_ext = {{(AW-2*WIDTH){mul_p[2*WIDTH-1]}}, mul_p};
    assign acc_sh   = acc >>> SHIFT;
    assign idx_inc  = idx + ADDR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len != '0) ? READ : POST;
            READ:    state_nxt = LOAD;
            LOAD:    state_nxt = MREQ;
            MREQ:    if (mul_ack) state_nxt = MWAIT;
            MWAIT:   if (mul_done) state_nxt = (idx_inc == len_q) ? POST : READ;
            POST:    state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_en     = 1'b0;
        mul_start = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        rd_addr   = idx;
        case (state)
            READ:    rd_en     = 1'b1;
            MREQ:    mul_start = 1'b1;
            OUT:     out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers; operands stay frozen from LOAD until the next LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            idx      <= '0;
            len_q    <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            out_data <= '0;
            sat      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc   <= bias_ext;
                    idx   <= '0;
                    len_q <= len;
                end
                LOAD: begin
                    mul_a <= x_data;
                    mul_b <= w_data;
                end
                MWAIT: if (mul_done) begin
                    acc <= acc + prod_ext;
                    idx <= idx_inc;
                end
                POST: {sat, out_data} <= relu_sat(acc_sh);
                OUT:  if (out_ready) sat <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// Directed bench for neuron_mac_ctrl with a behavioural operand memory and handshaking multiplier.
module tb_neuron_mac_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len_i = '0;
    logic [15:0] bias_i = '0;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [7:0]  x_data = '0;
    logic [7:0]  w_data = '0;
    logic [7:0]  mul_a, mul_b;
    logic        mul_start;
    logic        mul_ack;
    logic        mul_done;
    logic [15:0] mul_p;
    logic        busy, out_valid, sat;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;

    int n_chk = 0;
    int n_err = 0;

    logic signed [7:0] xm [0:15];
    logic signed [7:0] wm [0:15];

    neuron_mac_ctrl #(.WIDTH(8), .ADDR_W(8), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len_i), .bias(bias_i),
        .rd_en(rd_en), .rd_addr(rd_addr), .x_data(x_data), .w_data(w_data),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_ack(mul_ack),
        .mul_done(mul_done), .mul_p(mul_p), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .sat(sat)
    );

    always #5 clk = ~clk;

    // Operand memory: one cycle read latency
    always @(posedge clk) begin
        if (rd_en) begin
            x_data <= xm[rd_addr[3:0]];
            w_data <= wm[rd_addr[3:0]];
        end
    end

    // Multiplier model: ack after ACK_DLY cycles of request, done DONE_DLY cycles later
    localparam int ACK_DLY  = 1;
    localparam int DONE_DLY = 2;
    int                 mph, mcnt;
    logic               mack, mdone;
    logic signed [15:0] mp;
    assign mul_ack  = mack;
    assign mul_done = mdone;
    assign mul_p    = mp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mph <= 0; mcnt <= 0; mack <= 1'b0; mdone <= 1'b0; mp <= '0;
        end else begin
            case (mph)
                0: begin
                    mdone <= 1'b0;
                    if (mul_start) begin
                        if (mcnt >= ACK_DLY) begin
                            mack <= 1'b1;
                            mp   <= 16'($signed(mul_a)) * 16'($signed(mul_b));
                            mph  <= 1;
                            mcnt <= 0;
                        end else mcnt <= mcnt + 1;
                    end
                end
                1: begin
                    mack <= 1'b0;
                    mph  <= 2;
                end
                default: begin
                    if (mcnt >= DONE_DLY) begin
                        mdone <= 1'b1;
                        mph   <= 0;
                        mcnt  <= 0;
                    end else mcnt <= mcnt + 1;
                end
            endcase
        end
    end

    int   n_mstart = 0;
    int   n_rd = 0;
    logic ms_prev = 1'b0;
    always @(posedge clk) begin
        if (mul_start && !ms_prev) n_mstart++;
        if (rd_en) n_rd++;
        ms_prev <= mul_start;
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] l, input int b);
        @(posedge clk); #1;
        start = 1'b1; len_i = l; bias_i = 16'(b);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_valid"}, int'(out_valid), 1);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, "_vld_clr"}, int'(out_valid), 0);
        check_eq({tag, "_idle"}, int'(busy), 0);
    endtask

    int ms0, rd0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            xm[i] = '0;
            wm[i] = '0;
        end
        #12;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_valid", int'(out_valid), 0);
        check_eq("rst_mstart", int'(mul_start), 0);
        check_eq("rst_rden", int'(rd_en), 0);
        check_eq("rst_data", int'(out_data), 0);
        rst = 1'b0;

        // Dot product 1*4+2*5+3*6
        xm[0] = 8'sd1; xm[1] = 8'sd2; xm[2] = 8'sd3;
        wm[0] = 8'sd4; wm[1] = 8'sd5; wm[2] = 8'sd6;
        ms0 = n_mstart;
        do_start(8'd3, 0);
        check_eq("t1_busy", int'(busy), 1);
        wait_valid("t1");
        check_eq("t1_data", int'(out_data), 32);
        check_eq("t1_sat", int'(sat), 0);
        check_eq("t1_mstarts", n_mstart - ms0, 3);
        handshake("t1");

        // Negative sum clamps to zero
        xm[0] = -8'sd5; xm[1] = 8'sd3;
        wm[0] = 8'sd10; wm[1] = 8'sd2;
        do_start(8'd2, 4);
        wait_valid("t2");
        check_eq("t2_acc", int'($signed(dut.acc)), -40);
        check_eq("t2_data", int'(out_data), 0);
        check_eq("t2_sat", int'(sat), 0);
        handshake("t2");

        // Positive overflow saturates
        for (int i = 0; i < 4; i++) begin
            xm[i] = 8'sd127;
            wm[i] = 8'sd127;
        end
        do_start(8'd4, 0);
        wait_valid("t3");
        check_eq("t3_acc", int'($signed(dut.acc)), 64516);
        check_eq("t3_data", int'(out_data), 127);
        check_eq("t3_sat", int'(sat), 1);
        handshake("t3");
        check_eq("t3_sat_clr", int'(sat), 0);

        // Zero length: bias straight through, no memory or multiplier traffic
        ms0 = n_mstart; rd0 = n_rd;
        do_start(8'd0, 10);
        @(posedge clk); #1;
        check_eq("t4_valid", int'(out_valid), 1);
        check_eq("t4_data", int'(out_data), 10);
        check_eq("t4_rd", n_rd - rd0, 0);
        check_eq("t4_mstart", n_mstart - ms0, 0);
        handshake("t4");

        // Back-pressure on the result; a start during OUT must be ignored
        xm[0] = 8'sd1; xm[1] = 8'sd2; xm[2] = 8'sd3;
        wm[0] = 8'sd4; wm[1] = 8'sd5; wm[2] = 8'sd6;
        do_start(8'd3, 0);
        wait_valid("t5");
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            @(posedge clk); #1;
            start = 1'b0;
            check_eq("t5_hold_valid", int'(out_valid), 1);
            check_eq("t5_hold_data", int'(out_data), 32);
            check_eq("t5_hold_busy", int'(busy), 1);
        end
        rd0 = n_rd;
        handshake("t5");
        repeat (3) @(posedge clk);
        #1;
        check_eq("t5_no_restart", int'(busy), 0);
        check_eq("t5_no_read", n_rd - rd0, 0);

        // Reset in the middle of a multiply
        begin
            int n = 0;
            do_start(8'd3, 0);
            while (!mul_ack && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            check_eq("t6_ack_seen", int'(mul_ack), 1);
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        check_eq("t6_busy", int'(busy), 0);
        check_eq("t6_valid", int'(out_valid), 0);
        check_eq("t6_mstart", int'(mul_start), 0);
        check_eq("t6_rden", int'(rd_en), 0);
        check_eq("t6_rdaddr", int'(rd_addr), 0);
        check_eq("t6_mula", int'(mul_a), 0);
        check_eq("t6_mulb", int'(mul_b), 0);
        check_eq("t6_data", int'(out_data), 0);
        check_eq("t6_sat", int'(sat), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        xm[0] = 8'sd7; wm[0] = -8'sd3;
        do_start(8'd1, 30);
        wait_valid("t6b");
        check_eq("t6b_data", int'(out_data), 9);
        check_eq("t6b_sat", int'(sat), 0);
        handshake("t6b");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
